// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one word RAM between an instruction-fetch port and a load/store port.
// Sub-word stores become a two-cycle read-modify-write when RMW_EN is set.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter bit RMW_EN     = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_i_req,
   input  logic [ADDR_WIDTH-1:0] i_i_addr,
   output logic                  o_i_gnt,
   output logic                  o_i_rvalid,
   output logic [31:0]           o_i_rdata,
   input  logic                  i_d_req,
   input  logic                  i_d_we,
   input  logic [3:0]            i_d_be,
   input  logic [ADDR_WIDTH-1:0] i_d_addr,
   input  logic [31:0]           i_d_wdata,
   output logic                  o_d_gnt,
   output logic                  o_d_rvalid,
   output logic [31:0]           o_d_rdata,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [31:0]           o_ram_data,
   input  logic [31:0]           i_ram_data
);

   typedef enum logic {IDLE, RMW} state_t;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   state_t      state_reg;
   logic        last_grant_reg;
   logic        i_rvalid_reg;
   logic [31:0] i_rdata_reg;
   logic        d_rvalid_reg;
   logic [31:0] d_rdata_reg;
   logic [31:0] merge_reg;
   logic [31:0] merge_next;

   logic pick_d;
   logic d_full;
   logic d_partial;
   logic rmw_start;
   logic d_read;

   // Merged word for a partial store: enabled bytes from the requester, the rest from RAM.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign merge_next[8*gi +: 8] = i_d_be[gi] ? i_d_wdata[8*gi +: 8] : i_ram_data[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      pick_d     = i_d_req && (!i_i_req || (last_grant_reg == GRANT_I));
      d_full     = i_d_we && ((i_d_be == 4'hF) || (!RMW_EN && (i_d_be != 4'h0)));
      d_partial  = i_d_we && (i_d_be != 4'h0) && !d_full;
      o_i_gnt    = 1'b0;
      o_d_gnt    = 1'b0;
      o_ram_we   = 1'b0;
      o_ram_addr = '0;
      o_ram_data = 32'h0;
      rmw_start  = 1'b0;
      // Everything is forced quiet while reset is held, so an aborted RMW cannot write.
      if (i_rst_n) begin
         if (state_reg == RMW) begin
            o_ram_addr = i_d_addr;
            o_ram_we   = 1'b1;
            o_ram_data = merge_reg;
            o_d_gnt    = 1'b1;
         end else if (pick_d) begin
            o_ram_addr = i_d_addr;
            if (d_partial) begin
               rmw_start = 1'b1;
            end else begin
               o_d_gnt = 1'b1;
               if (d_full) begin
                  o_ram_we   = 1'b1;
                  o_ram_data = i_d_wdata;
               end
            end
         end else if (i_i_req) begin
            o_ram_addr = i_i_addr;
            o_i_gnt    = 1'b1;
         end
      end
      d_read = o_d_gnt && (state_reg == IDLE) && !i_d_we;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= GRANT_I;
         i_rvalid_reg   <= 1'b0;
         i_rdata_reg    <= 32'h0;
         d_rvalid_reg   <= 1'b0;
         d_rdata_reg    <= 32'h0;
         merge_reg      <= 32'h0;
      end else begin
         i_rvalid_reg <= o_i_gnt;
         if (o_i_gnt) i_rdata_reg <= i_ram_data;
         d_rvalid_reg <= d_read;
         if (d_read) d_rdata_reg <= i_ram_data;

         if (o_i_gnt)      last_grant_reg <= GRANT_I;
         else if (o_d_gnt) last_grant_reg <= GRANT_D;

         case (state_reg)
            IDLE: begin
               if (rmw_start) begin
                  merge_reg <= merge_next;
                  state_reg <= RMW;
               end
            end
            RMW:     state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign o_i_rvalid = i_rvalid_reg;
   assign o_i_rdata  = i_rdata_reg;
   assign o_d_rvalid = d_rvalid_reg;
   assign o_d_rdata  = d_rdata_reg;

endmodule
